// File: rtl/cpu_trace_buffer_if.sv
// Trace buffer bus: retire-side commit stream
// and valid/ready drain port for captured entries.
interface cpu_trace_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int SEQ_W  = 16
);
  logic              commit_valid;
  logic [ADDR_W-1:0] commit_pc;
  logic [DATA_W-1:0] commit_instr;
  logic              commit_rf_we;
  logic [REG_W-1:0]  commit_rf_idx;
  logic [DATA_W-1:0] commit_rf_data;

  logic              rd_valid;
  logic              rd_ready;
  logic [SEQ_W-1:0]  rd_seq;
  logic [ADDR_W-1:0] rd_pc;
  logic [DATA_W-1:0] rd_instr;
  logic              rd_rf_we;
  logic [REG_W-1:0]  rd_rf_idx;
  logic [DATA_W-1:0] rd_rf_data;

  modport master (
    output commit_valid, commit_pc, commit_instr,
    output commit_rf_we, commit_rf_idx, commit_rf_data,
    output rd_ready,
    input  rd_valid, rd_seq, rd_pc, rd_instr,
    input  rd_rf_we, rd_rf_idx, rd_rf_data
  );

  modport slave (
    input  commit_valid, commit_pc, commit_instr,
    input  commit_rf_we, commit_rf_idx, commit_rf_data,
    input  rd_ready,
    output rd_valid, rd_seq, rd_pc, rd_instr,
    output rd_rf_we, rd_rf_idx, rd_rf_data
  );
endinterface

// File: rtl/cpu_trace_buffer.sv
// Execution trace capture: circular pre-trigger history,
// PC-match trigger, post-trigger count, valid/ready drain.
module cpu_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int SEQ_W  = 16,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     trig_en,
  input  logic [ADDR_W-1:0]        trig_pc,
  input  logic [CNT_W-1:0]         post_cnt,
  input  logic                     mode_wrap,
  cpu_trace_buffer_if.slave        bus,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         dropped
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE, S_ARMED, S_TRIG, S_DONE
  } state_e;

  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic              rf_we;
    logic [REG_W-1:0]  rf_idx;
    logic [DATA_W-1:0] rf_data;
  } entry_t;

  state_e            state_q, state_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [PW:0]       count_q, count_d;
  logic [CNT_W-1:0]  dropped_q, dropped_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic              we;
  logic              full;
  logic              pop;
  entry_t            mem [DEPTH];
  entry_t            wr_e;
  entry_t            head;

  assign full = (count_q == FULL_CNT);
  assign head = mem[rptr_q];
  assign bus.rd_valid = (state_q == S_DONE) && (count_q != '0);
  assign pop = bus.rd_valid && bus.rd_ready;

  assign bus.rd_seq     = head.seq;
  assign bus.rd_pc      = head.pc;
  assign bus.rd_instr   = head.instr;
  assign bus.rd_rf_we   = head.rf_we;
  assign bus.rd_rf_idx  = head.rf_idx;
  assign bus.rd_rf_data = head.rf_data;

  assign wr_e = '{
    seq:     seq_q,
    pc:      bus.commit_pc,
    instr:   bus.commit_instr,
    rf_we:   bus.commit_rf_we,
    rf_idx:  bus.commit_rf_idx,
    rf_data: bus.commit_rf_data
  };

  assign state   = state_q;
  assign count   = count_q;
  assign dropped = dropped_q;

  // Next-state: arm wins, then per-state commit/pop handling
  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    dropped_d = dropped_q;
    rem_d     = rem_q;
    seq_d     = seq_q;
    we        = 1'b0;
    if (arm) begin
      state_d   = trig_en ? S_ARMED : S_TRIG;
      wptr_d    = '0;
      rptr_d    = '0;
      count_d   = '0;
      dropped_d = '0;
      seq_d     = '0;
      rem_d     = post_cnt;
    end else begin
      unique case (state_q)
        S_ARMED: begin
          if (bus.commit_valid) begin
            we     = 1'b1;
            wptr_d = wptr_q + 1'b1;
            seq_d  = seq_q + 1'b1;
            if (full) rptr_d = rptr_q + 1'b1;
            else      count_d = count_q + 1'b1;
            if (bus.commit_pc == trig_pc)
              state_d = (rem_q == '0) ? S_DONE : S_TRIG;
          end
        end
        S_TRIG: begin
          if (bus.commit_valid) begin
            if (rem_q == '0) begin
              // zero post count from an immediate arm
              state_d = S_DONE;
            end else begin
              rem_d = rem_q - 1'b1;
              seq_d = seq_q + 1'b1;
              if (rem_q == CNT_W'(1)) state_d = S_DONE;
              if (!full) begin
                we      = 1'b1;
                wptr_d  = wptr_q + 1'b1;
                count_d = count_q + 1'b1;
              end else begin
                dropped_d = (&dropped_q) ? dropped_q
                          : dropped_q + 1'b1;
                if (mode_wrap) begin
                  we     = 1'b1;
                  wptr_d = wptr_q + 1'b1;
                  rptr_d = rptr_q + 1'b1;
                end
              end
            end
          end
        end
        S_DONE: begin
          if (pop) begin
            rptr_d  = rptr_q + 1'b1;
            count_d = count_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      dropped_q <= '0;
      rem_q     <= '0;
      seq_q     <= '0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      dropped_q <= dropped_d;
      rem_q     <= rem_d;
      seq_q     <= seq_d;
    end
  end

  // Entry storage, intentionally not reset
  always_ff @(posedge clk) begin
    if (we) mem[wptr_q] <= wr_e;
  end
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: two
// instances (DEPTH 16 and DEPTH 4).
module tb_cpu_trace_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_arm, a_ten, a_wrap;
  logic [31:0] a_tpc;
  logic [7:0]  a_post;
  logic [1:0]  a_state;
  logic [4:0]  a_count;
  logic [7:0]  a_drop;

  logic        b_arm, b_ten, b_wrap;
  logic [31:0] b_tpc;
  logic [7:0]  b_post;
  logic [1:0]  b_state;
  logic [2:0]  b_count;
  logic [7:0]  b_drop;

  cpu_trace_buffer_if if_a ();
  cpu_trace_buffer_if if_b ();

  cpu_trace_buffer #(.DEPTH(16)) u_a (
    .clk(clk), .rst(rst), .arm(a_arm),
    .trig_en(a_ten), .trig_pc(a_tpc),
    .post_cnt(a_post), .mode_wrap(a_wrap),
    .bus(if_a), .state(a_state),
    .count(a_count), .dropped(a_drop)
  );

  cpu_trace_buffer #(.DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .arm(b_arm),
    .trig_en(b_ten), .trig_pc(b_tpc),
    .post_cnt(b_post), .mode_wrap(b_wrap),
    .bus(if_b), .state(b_state),
    .count(b_count), .dropped(b_drop)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] q_pc[$];
  logic [15:0] q_seq[$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h",
                  tag, got, exp);
  endtask

  function automatic logic rv(bit s);
    return s ? if_b.rd_valid : if_a.rd_valid;
  endfunction
  function automatic logic [31:0] rpc(bit s);
    return s ? if_b.rd_pc : if_a.rd_pc;
  endfunction
  function automatic logic [15:0] rseq(bit s);
    return s ? if_b.rd_seq : if_a.rd_seq;
  endfunction
  function automatic logic [1:0] st(bit s);
    return s ? b_state : a_state;
  endfunction
  function automatic logic [4:0] cnt(bit s);
    return s ? {2'b0, b_count} : a_count;
  endfunction
  function automatic logic [7:0] drp(bit s);
    return s ? b_drop : a_drop;
  endfunction

  task automatic set_commit(bit s, bit v,
                            logic [31:0] pc);
    if (s) begin
      if_b.commit_valid   = v;
      if_b.commit_pc      = pc;
      if_b.commit_instr   = 32'h1000_0000 | pc;
      if_b.commit_rf_we   = pc[2];
      if_b.commit_rf_idx  = pc[6:2];
      if_b.commit_rf_data = ~pc;
    end else begin
      if_a.commit_valid   = v;
      if_a.commit_pc      = pc;
      if_a.commit_instr   = 32'h1000_0000 | pc;
      if_a.commit_rf_we   = pc[2];
      if_a.commit_rf_idx  = pc[6:2];
      if_a.commit_rf_data = ~pc;
    end
  endtask

  task automatic set_ready(bit s, bit r);
    if (s) if_b.rd_ready = r;
    else   if_a.rd_ready = r;
  endtask

  task automatic do_arm(bit s, bit te,
                        logic [31:0] tp,
                        logic [7:0] pn,
                        bit wrap, bit cv);
    @(negedge clk);
    if (s) begin
      b_arm = 1; b_ten = te; b_tpc = tp;
      b_post = pn; b_wrap = wrap;
    end else begin
      a_arm = 1; a_ten = te; a_tpc = tp;
      a_post = pn; a_wrap = wrap;
    end
    if (cv) set_commit(s, 1'b1, tp);
    @(posedge clk); #1;
    a_arm = 0; b_arm = 0;
    set_commit(s, 1'b0, 32'h0);
  endtask

  task automatic commit(bit s, logic [31:0] pc);
    @(negedge clk);
    set_commit(s, 1'b1, pc);
    @(posedge clk); #1;
    set_commit(s, 1'b0, 32'h0);
  endtask

  task automatic commits(bit s, logic [31:0] lo,
                         logic [31:0] hi);
    for (logic [31:0] p = lo; p <= hi; p += 4)
      commit(s, p);
  endtask

  task automatic drain(bit s);
    q_pc.delete();
    q_seq.delete();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!rv(s)) break;
      q_pc.push_back(rpc(s));
      q_seq.push_back(rseq(s));
      set_ready(s, 1'b1);
      @(posedge clk); #1;
      set_ready(s, 1'b0);
    end
  endtask

  initial begin
    a_arm = 0; a_ten = 0; a_tpc = 0;
    a_post = 0; a_wrap = 0;
    b_arm = 0; b_ten = 0; b_tpc = 0;
    b_post = 0; b_wrap = 0;
    set_commit(0, 0, 0); set_commit(1, 0, 0);
    set_ready(0, 0); set_ready(1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 64'(a_state), 0);
    chk("rst_count", 64'(a_count), 0);
    chk("rst_rvalid", 64'(if_a.rd_valid), 0);
    chk("rst_drop", 64'(a_drop), 0);
    rst = 1;

    // async reset mid-capture
    do_arm(0, 1, 32'hFFFF_FFF0, 8'd1, 0, 0);
    commits(0, 32'h0, 32'h8);
    chk("t1_pre_cnt", 64'(cnt(0)), 3);
    chk("t1_pre_st", 64'(st(0)), 1);
    @(negedge clk);
    rst = 0;
    #1;
    chk("t1_st", 64'(st(0)), 0);
    chk("t1_cnt", 64'(cnt(0)), 0);
    chk("t1_rv", 64'(rv(0)), 0);
    @(negedge clk);
    rst = 1;

    // immediate trigger, post 4
    do_arm(0, 0, 32'h0, 8'd4, 0, 0);
    chk("t2_st_trig", 64'(st(0)), 2);
    commits(0, 32'h0, 32'hC);
    chk("t2_st_done", 64'(st(0)), 3);
    commit(0, 32'h10);
    chk("t2_cnt", 64'(cnt(0)), 4);
    chk("t2_instr", 64'(if_a.rd_instr), 64'h1000_0000);
    chk("t2_rfidx", 64'(if_a.rd_rf_idx), 0);
    chk("t2_rfdat", 64'(if_a.rd_rf_data), 64'hFFFF_FFFF);
    drain(0);
    chk("t2_n", 64'(q_pc.size()), 4);
    chk("t2_pc0", 64'(q_pc[0]), 0);
    chk("t2_pc3", 64'(q_pc[3]), 32'hC);
    chk("t2_seq3", 64'(q_seq[3]), 3);
    chk("t2_rv_end", 64'(rv(0)), 0);

    // PC trigger, pre-trigger history, wrap
    do_arm(0, 1, 32'h40, 8'd2, 1, 0);
    commits(0, 32'h0, 32'h3C);
    chk("t3_armed", 64'(st(0)), 1);
    chk("t3_full", 64'(cnt(0)), 16);
    chk("t3_drop_pre", 64'(drp(0)), 0);
    commits(0, 32'h40, 32'h50);
    chk("t3_st", 64'(st(0)), 3);
    chk("t3_cnt", 64'(cnt(0)), 16);
    chk("t3_drop", 64'(drp(0)), 2);
    drain(0);
    chk("t3_n", 64'(q_pc.size()), 16);
    chk("t3_first", 64'(q_pc[0]), 32'hC);
    chk("t3_last", 64'(q_pc[15]), 32'h48);
    chk("t3_seq0", 64'(q_seq[0]), 3);
    chk("t3_seq15", 64'(q_seq[15]), 18);

    // DEPTH 4, discard newest
    do_arm(1, 0, 32'h0, 8'd6, 0, 0);
    commits(1, 32'h0, 32'h14);
    chk("t4a_st", 64'(st(1)), 3);
    chk("t4a_drop", 64'(drp(1)), 2);
    chk("t4a_cnt", 64'(cnt(1)), 4);
    drain(1);
    chk("t4a_n", 64'(q_pc.size()), 4);
    chk("t4a_first", 64'(q_pc[0]), 0);
    chk("t4a_last", 64'(q_pc[3]), 32'hC);

    // DEPTH 4, overwrite oldest
    do_arm(1, 0, 32'h0, 8'd6, 1, 0);
    commits(1, 32'h0, 32'h14);
    chk("t4b_drop", 64'(drp(1)), 2);
    drain(1);
    chk("t4b_n", 64'(q_pc.size()), 4);
    chk("t4b_first", 64'(q_pc[0]), 32'h8);
    chk("t4b_last", 64'(q_pc[3]), 32'h14);
    chk("t4b_seq0", 64'(q_seq[0]), 2);

    // backpressure on the drain port
    do_arm(0, 0, 32'h0, 8'd3, 0, 0);
    commits(0, 32'h0, 32'h8);
    chk("t5_cnt", 64'(cnt(0)), 3);
    begin
      logic [4:0] pat;
      int pops;
      bit stable;
      logic [31:0] pc_b;
      pat = 5'b11001;
      pops = 0;
      stable = 1;
      q_pc.delete();
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        pc_b = rpc(0);
        set_ready(0, pat[4-i]);
        if (rv(0) && pat[4-i]) begin
          pops++;
          q_pc.push_back(pc_b);
        end
        @(posedge clk); #1;
        if (!pat[4-i] && rpc(0) !== pc_b)
          stable = 0;
      end
      set_ready(0, 0);
      chk("t5_pops", 64'(pops), 3);
      chk("t5_stable", 64'(stable), 1);
      chk("t5_pc1", 64'(q_pc[1]), 32'h4);
      chk("t5_pc2", 64'(q_pc[2]), 32'h8);
      chk("t5_rv_end", 64'(rv(0)), 0);
    end

    // zero post count on immediate trigger
    do_arm(0, 0, 32'h0, 8'd0, 0, 0);
    commit(0, 32'h20);
    chk("tz_st", 64'(st(0)), 3);
    chk("tz_cnt", 64'(cnt(0)), 0);

    // arm beats concurrent commit in DONE
    do_arm(0, 0, 32'h0, 8'd5, 0, 0);
    commits(0, 32'h0, 32'h10);
    chk("t6_pre_cnt", 64'(cnt(0)), 5);
    do_arm(0, 1, 32'h80, 8'd0, 0, 1);
    chk("t6_cnt", 64'(cnt(0)), 0);
    chk("t6_st", 64'(st(0)), 1);
    commit(0, 32'h80);
    chk("t6_done", 64'(st(0)), 3);
    drain(0);
    chk("t6_n", 64'(q_pc.size()), 1);
    chk("t6_seq", 64'(q_seq[0]), 0);
    chk("t6_pc", 64'(q_pc[0]), 32'h80);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
